// File: rtl/issue_pkg.sv
// Shared types for the issue stage: function encodings, FU classes, issue packet, rename entry.
// Packet and rename field widths track the default issue_ctrl parameters.
package issue_pkg;

    localparam int unsigned PKT_FUNC_W = 4;
    localparam int unsigned PKT_REG_W  = 4;
    localparam int unsigned PKT_IDX_W  = 3;

    localparam logic [PKT_FUNC_W-1:0] FUNC_ADD = 4'b0000;
    localparam logic [PKT_FUNC_W-1:0] FUNC_SUB = 4'b0001;
    localparam logic [PKT_FUNC_W-1:0] FUNC_MUL = 4'b0010;
    localparam logic [PKT_FUNC_W-1:0] FUNC_DIV = 4'b0011;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_MUL,
        CLS_ILLEGAL
    } fu_class_e;

    typedef struct packed {
        logic [PKT_FUNC_W-1:0] func;
        logic [PKT_REG_W-1:0]  rd;
        logic [PKT_IDX_W-1:0]  rob_idx;
        logic                  rs1_pend;
        logic [PKT_IDX_W-1:0]  rs1_tag;
        logic                  rs2_pend;
        logic [PKT_IDX_W-1:0]  rs2_tag;
    } issue_pkt_t;

    typedef struct packed {
        logic                 busy;
        logic [PKT_IDX_W-1:0] tag;
    } rename_ent_t;

    function automatic fu_class_e classify(input logic [PKT_FUNC_W-1:0] func);
        fu_class_e cls;
        case (func)
            FUNC_ADD, FUNC_SUB: cls = CLS_ADD;
            FUNC_MUL, FUNC_DIV: cls = CLS_MUL;
            default:            cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rename_table.sv
// Register rename table: two combinational read ports, one rename write and one
// tag-matched clear; the write wins when both hit the same entry.
module rename_table
    import issue_pkg::*;
#(
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned REG_W     = 4
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [REG_W-1:0]     rd_addr_a,
    input  logic [REG_W-1:0]     rd_addr_b,
    output rename_ent_t          rd_ent_a,
    output rename_ent_t          rd_ent_b,
    input  logic                 wr_en,
    input  logic [REG_W-1:0]     wr_addr,
    input  logic [PKT_IDX_W-1:0] wr_tag,
    input  logic                 clr_en,
    input  logic [REG_W-1:0]     clr_addr,
    input  logic [PKT_IDX_W-1:0] clr_tag
);

    rename_ent_t tab_q [REG_COUNT];

    assign rd_ent_a = tab_q[rd_addr_a];
    assign rd_ent_b = tab_q[rd_addr_b];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            tab_q <= '{default: '0};
        end else if (flush) begin
            tab_q <= '{default: '0};
        end else begin
            // Only clear if the retiring producer is still the newest mapping.
            if (clr_en && tab_q[clr_addr].busy && (tab_q[clr_addr].tag == clr_tag)) begin
                tab_q[clr_addr].busy <= 1'b0;
            end
            if (wr_en) begin
                tab_q[wr_addr] <= '{busy: 1'b1, tag: wr_tag};
            end
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// Tomasulo issue stage: ROB/RS allocation, source renaming and a registered issue packet.
// Optional stall counter output perf_stall_cnt is built when ISSUE_STALL_CNT_EN is defined.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = 8,
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned REG_W     = 4,
    parameter int unsigned FUNC_W    = 4,
    parameter int unsigned ADD_RS    = 2,
    parameter int unsigned MUL_RS    = 2,
    localparam int unsigned IDX_W    = $clog2(ROB_DEPTH),
    localparam int unsigned ADD_CW   = $clog2(ADD_RS + 1),
    localparam int unsigned MUL_CW   = $clog2(MUL_RS + 1)
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              add_rs_free,
    input  logic              mul_rs_free,
    input  logic              rob_commit,
    input  logic              flush,
`ifdef ISSUE_STALL_CNT_EN
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic              out_valid,
    output logic [FUNC_W-1:0] out_func,
    output logic [REG_W-1:0]  out_rd,
    output logic [IDX_W-1:0]  out_rob_idx,
    output logic              out_rs1_pend,
    output logic              out_rs2_pend,
    output logic [IDX_W-1:0]  out_rs1_tag,
    output logic [IDX_W-1:0]  out_rs2_tag,
    output logic [IDX_W-1:0]  rob_head,
    output logic [IDX_W:0]    rob_count,
    output logic [ADD_CW-1:0] add_count,
    output logic [MUL_CW-1:0] mul_count,
    output logic              err_illegal,
    output logic              err_underflow
);

    localparam logic [IDX_W:0]    ROB_FULL = ROB_DEPTH[IDX_W:0];
    localparam logic [ADD_CW-1:0] ADD_MAX  = ADD_RS[ADD_CW-1:0];
    localparam logic [MUL_CW-1:0] MUL_MAX  = MUL_RS[MUL_CW-1:0];

    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [ADD_CW-1:0] add_q, add_d;
    logic [MUL_CW-1:0] mul_q, mul_d;
    logic              valid_q, valid_d;
    logic              err_ill_q, err_ill_d, err_unf_q, err_unf_d;
    issue_pkt_t        pkt_q, pkt_d;

    // Commit only needs the destination register to retire the rename mapping.
    logic [REG_W-1:0]  rob_rd_q [ROB_DEPTH];

    fu_class_e   cls;
    logic        cls_room, acc_legal, acc_ill, commit_ok;
    logic        add_inc, mul_inc, add_dec, mul_dec;
    rename_ent_t rs1_ent, rs2_ent;

    always_comb begin
        cls      = classify(in_func);
        cls_room = 1'b0;
        case (cls)
            CLS_ADD: cls_room = add_q < ADD_MAX;
            CLS_MUL: cls_room = mul_q < MUL_MAX;
            default: cls_room = 1'b0;
        endcase
        in_ready  = !flush && ((cls == CLS_ILLEGAL) || ((cnt_q < ROB_FULL) && cls_room));
        acc_legal = in_valid && in_ready && (cls != CLS_ILLEGAL);
        acc_ill   = in_valid && in_ready && (cls == CLS_ILLEGAL);
        commit_ok = rob_commit && (cnt_q != '0) && !flush;
        add_inc   = acc_legal && (cls == CLS_ADD);
        mul_inc   = acc_legal && (cls == CLS_MUL);
        add_dec   = add_rs_free && (add_q != '0) && !flush;
        mul_dec   = mul_rs_free && (mul_q != '0) && !flush;
    end

    always_comb begin
        head_d    = head_q + IDX_W'(commit_ok);
        tail_d    = tail_q + IDX_W'(acc_legal);
        cnt_d     = cnt_q + (IDX_W+1)'(acc_legal) - (IDX_W+1)'(commit_ok);
        add_d     = add_q + ADD_CW'(add_inc) - ADD_CW'(add_dec);
        mul_d     = mul_q + MUL_CW'(mul_inc) - MUL_CW'(mul_dec);
        valid_d   = acc_legal;
        err_ill_d = acc_ill;
        err_unf_d = !flush && ((rob_commit && (cnt_q == '0)) ||
                               (add_rs_free && (add_q == '0)) ||
                               (mul_rs_free && (mul_q == '0)));
        pkt_d     = '0;
        if (acc_legal) begin
            pkt_d.func     = in_func;
            pkt_d.rd       = in_rd;
            pkt_d.rob_idx  = tail_q;
            pkt_d.rs1_pend = rs1_ent.busy;
            pkt_d.rs1_tag  = rs1_ent.busy ? rs1_ent.tag : '0;
            pkt_d.rs2_pend = rs2_ent.busy;
            pkt_d.rs2_tag  = rs2_ent.busy ? rs2_ent.tag : '0;
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
            add_d  = '0;
            mul_d  = '0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            add_q     <= '0;
            mul_q     <= '0;
            valid_q   <= 1'b0;
            err_ill_q <= 1'b0;
            err_unf_q <= 1'b0;
            pkt_q     <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            add_q     <= add_d;
            mul_q     <= mul_d;
            valid_q   <= valid_d;
            err_ill_q <= err_ill_d;
            err_unf_q <= err_unf_d;
            pkt_q     <= pkt_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (acc_legal) begin
            rob_rd_q[tail_q] <= in_rd;
        end
    end

    rename_table #(
        .REG_COUNT (REG_COUNT),
        .REG_W     (REG_W)
    ) u_rename (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .flush     (flush),
        .rd_addr_a (in_rs1),
        .rd_addr_b (in_rs2),
        .rd_ent_a  (rs1_ent),
        .rd_ent_b  (rs2_ent),
        .wr_en     (acc_legal),
        .wr_addr   (in_rd),
        .wr_tag    (tail_q),
        .clr_en    (commit_ok),
        .clr_addr  (rob_rd_q[head_q]),
        .clr_tag   (head_q)
    );

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (in_valid && !in_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
`endif

    assign out_valid     = valid_q;
    assign out_func      = pkt_q.func;
    assign out_rd        = pkt_q.rd;
    assign out_rob_idx   = pkt_q.rob_idx;
    assign out_rs1_pend  = pkt_q.rs1_pend;
    assign out_rs1_tag   = pkt_q.rs1_tag;
    assign out_rs2_pend  = pkt_q.rs2_pend;
    assign out_rs2_tag   = pkt_q.rs2_tag;
    assign rob_head      = head_q;
    assign rob_count     = cnt_q;
    assign add_count     = add_q;
    assign mul_count     = mul_q;
    assign err_illegal   = err_ill_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_issue_ctrl;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_func = '0, in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic       add_rs_free = 1'b0, mul_rs_free = 1'b0, rob_commit = 1'b0, flush = 1'b0;
    logic       out_valid;
    logic [3:0] out_func, out_rd;
    logic [2:0] out_rob_idx, out_rs1_tag, out_rs2_tag, rob_head;
    logic       out_rs1_pend, out_rs2_pend;
    logic [3:0] rob_count;
    logic [1:0] add_count, mul_count;
    logic       err_illegal, err_underflow;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    issue_ctrl dut (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_func       (in_func),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .add_rs_free   (add_rs_free),
        .mul_rs_free   (mul_rs_free),
        .rob_commit    (rob_commit),
        .flush         (flush),
`ifdef ISSUE_STALL_CNT_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .out_valid     (out_valid),
        .out_func      (out_func),
        .out_rd        (out_rd),
        .out_rob_idx   (out_rob_idx),
        .out_rs1_pend  (out_rs1_pend),
        .out_rs2_pend  (out_rs2_pend),
        .out_rs1_tag   (out_rs1_tag),
        .out_rs2_tag   (out_rs2_tag),
        .rob_head      (rob_head),
        .rob_count     (rob_count),
        .add_count     (add_count),
        .mul_count     (mul_count),
        .err_illegal   (err_illegal),
        .err_underflow (err_underflow)
    );

    initial forever #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cnt = 0, m_head = 0, m_tail = 0, m_add = 0, m_mul = 0;
    int          m_rd_q[$];
    bit          m_busy[16];
    int          m_tag[16];
    int unsigned m_perf = 0;
    int e_valid = 0, e_func = 0, e_rd = 0, e_idx = 0;
    int e_p1 = 0, e_t1 = 0, e_p2 = 0, e_t2 = 0, e_ill = 0, e_unf = 0;

    function automatic int cls_of(input int f);
        if (f < 2) return 0;
        if (f < 4) return 1;
        return 2;
    endfunction

    function automatic bit exp_ready();
        int c = cls_of(int'(in_func));
        if (flush) return 1'b0;
        if (c == 2) return 1'b1;
        if (m_cnt >= 8) return 1'b0;
        return (c == 0) ? (m_add < 2) : (m_mul < 2);
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_head = 0; m_tail = 0; m_add = 0; m_mul = 0;
        m_rd_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_busy[i] = 1'b0;
            m_tag[i]  = 0;
        end
        e_valid = 0; e_func = 0; e_rd = 0; e_idx = 0;
        e_p1 = 0; e_t1 = 0; e_p2 = 0; e_t2 = 0; e_ill = 0; e_unf = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk1 or negedge rst_n);
            if (!rst_n) begin
                m_reset();
                m_perf = 0;
            end else begin
                bit rdy, acc;
                int c, p1, t1, p2, t2, unf, crd;
                rdy = exp_ready();
                c   = cls_of(int'(in_func));
                if (in_valid && !rdy && !flush && m_perf != 32'hFFFF_FFFF) m_perf++;
                if (flush) begin
                    m_reset();
                end else begin
                    p1 = m_busy[in_rs1] ? 1 : 0;
                    t1 = p1 ? m_tag[in_rs1] : 0;
                    p2 = m_busy[in_rs2] ? 1 : 0;
                    t2 = p2 ? m_tag[in_rs2] : 0;
                    unf = 0;
                    if (rob_commit) begin
                        if (m_cnt > 0) begin
                            crd = m_rd_q.pop_front();
                            if (m_busy[crd] && m_tag[crd] == m_head) m_busy[crd] = 1'b0;
                            m_head = (m_head + 1) % 8;
                            m_cnt--;
                        end else unf = 1;
                    end
                    if (add_rs_free) begin
                        if (m_add > 0) m_add--; else unf = 1;
                    end
                    if (mul_rs_free) begin
                        if (m_mul > 0) m_mul--; else unf = 1;
                    end
                    acc = in_valid && rdy;
                    e_valid = 0; e_func = 0; e_rd = 0; e_idx = 0;
                    e_p1 = 0; e_t1 = 0; e_p2 = 0; e_t2 = 0;
                    e_unf = unf;
                    e_ill = (acc && c == 2) ? 1 : 0;
                    if (acc && c != 2) begin
                        e_valid = 1; e_func = int'(in_func); e_rd = int'(in_rd); e_idx = m_tail;
                        e_p1 = p1; e_t1 = t1; e_p2 = p2; e_t2 = t2;
                        m_busy[in_rd] = 1'b1;
                        m_tag[in_rd]  = m_tail;
                        m_rd_q.push_back(int'(in_rd));
                        m_tail = (m_tail + 1) % 8;
                        m_cnt++;
                        if (c == 0) m_add++; else m_mul++;
                    end
                end
            end
        end
    end

    // Per-cycle compare, mid-cycle on the falling edge.
    initial forever begin
        @(negedge clk1);
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(exp_ready()));
            chk("out_valid", int'(out_valid), e_valid);
            chk("out_func", int'(out_func), e_func);
            chk("out_rd", int'(out_rd), e_rd);
            chk("out_rob_idx", int'(out_rob_idx), e_idx);
            chk("out_rs1_pend", int'(out_rs1_pend), e_p1);
            chk("out_rs1_tag", int'(out_rs1_tag), e_t1);
            chk("out_rs2_pend", int'(out_rs2_pend), e_p2);
            chk("out_rs2_tag", int'(out_rs2_tag), e_t2);
            chk("rob_head", int'(rob_head), m_head);
            chk("rob_count", int'(rob_count), m_cnt);
            chk("add_count", int'(add_count), m_add);
            chk("mul_count", int'(mul_count), m_mul);
            chk("err_illegal", int'(err_illegal), e_ill);
            chk("err_underflow", int'(err_underflow), e_unf);
`ifdef ISSUE_STALL_CNT_EN
            chk("perf_stall_cnt", int'(perf_stall_cnt), int'(m_perf));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply(input bit v, input int f, input int r1, input int r2, input int rd,
                         input bit af, input bit mf, input bit cm, input bit fl);
        in_valid = v; in_func = 4'(f); in_rs1 = 4'(r1); in_rs2 = 4'(r2); in_rd = 4'(rd);
        add_rs_free = af; mul_rs_free = mf; rob_commit = cm; flush = fl;
    endtask

    task automatic idle();
        apply(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk1);
        #2;
    endtask

    task automatic step(input bit v, input int f, input int r1, input int r2, input int rd,
                        input bit af, input bit mf, input bit cm, input bit fl);
        apply(v, f, r1, r2, rd, af, mf, cm, fl);
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_rob_count", int'(rob_count), 0);
        chk("rst_rob_head", int'(rob_head), 0);
        chk("rst_counts", int'({add_count, mul_count}), 0);
        chk("rst_errs", int'({err_illegal, err_underflow}), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        do_reset();

        // ADD r3 <- r1, r2
        step(1, 0, 1, 2, 3, 0, 0, 0, 0);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_idx", int'(out_rob_idx), 0);
        chk("t1_pend", int'({out_rs1_pend, out_rs2_pend}), 0);
        chk("t1_rob_count", int'(rob_count), 1);
        chk("t1_add_count", int'(add_count), 1);

        // Dependency through the rename table
        do_reset();
        step(1, 0, 1, 1, 5, 0, 0, 0, 0);
        step(1, 2, 5, 5, 6, 0, 0, 0, 0);
        chk("t2_pend", int'({out_rs1_pend, out_rs2_pend}), 3);
        chk("t2_tags", int'({out_rs1_tag, out_rs2_tag}), 0);
        chk("t2_idx", int'(out_rob_idx), 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t2_head", int'(rob_head), 1);
        step(1, 1, 5, 5, 7, 1, 0, 0, 0);
        chk("t2_pend_after_commit", int'({out_rs1_pend, out_rs2_pend}), 0);
        chk("t2_idx3", int'(out_rob_idx), 2);

        // Add RS full, held until a release
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 3, 0, 0, 0, 0);
        #1 chk("t3_stall_ready", int'(in_ready), 0);
        tick();
        chk("t3_no_valid", int'(out_valid), 0);
        add_rs_free = 1'b1;
        #1 chk("t3_free_not_same_cycle", int'(in_ready), 0);
        tick();
        add_rs_free = 1'b0;
        #1 chk("t3_ready_after_free", int'(in_ready), 1);
        chk("t3_add_count1", int'(add_count), 1);
        tick();
        idle();
        chk("t3_accepted", int'(out_valid), 1);
        chk("t3_idx", int'(out_rob_idx), 2);
        chk("t3_add_count2", int'(add_count), 2);

        // Fill the ROB, then wrap
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1, (i % 2) * 2, 0, 0, i + 1, (i % 2) == 1, (i > 0) && (i % 2) == 0, 0, 0);
        chk("t4_full_count", int'(rob_count), 8);
        chk("t4_counts", int'({add_count, mul_count}), 1);
        apply(1, 0, 0, 0, 9, 0, 0, 0, 0);
        #1 chk("t4_full_ready", int'(in_ready), 0);
        tick();
        rob_commit = 1'b1;
        #1 chk("t4_commit_not_same_cycle", int'(in_ready), 0);
        tick();
        rob_commit = 1'b0;
        #1 chk("t4_ready_after_commit", int'(in_ready), 1);
        tick();
        idle();
        chk("t4_wrap_idx", int'(out_rob_idx), 0);
        chk("t4_head", int'(rob_head), 1);
        chk("t4_count", int'(rob_count), 8);
`ifdef ISSUE_STALL_CNT_EN
        chk("t4_perf", int'(perf_stall_cnt), 2);
`endif

        // Stale commit must not clear a newer mapping
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 2, 1, 0, 0, 0);
        step(1, 0, 0, 0, 4, 1, 0, 0, 0);
        step(1, 2, 0, 0, 4, 0, 0, 0, 0);
        chk("t5_idx", int'(out_rob_idx), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 4, 4, 8, 1, 0, 0, 0);
        chk("t5_pend", int'({out_rs1_pend, out_rs2_pend}), 3);
        chk("t5_tag1", int'(out_rs1_tag), 3);
        chk("t5_tag2", int'(out_rs2_tag), 3);
        chk("t5_idx2", int'(out_rob_idx), 4);

        // Flush dominance, then illegal and underflow
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1, (i % 2) * 2, 0, 0, i + 1, (i % 2) == 1, (i > 0) && (i % 2) == 0, 0, 0);
        chk("t6_count5", int'(rob_count), 5);
        apply(1, 0, 1, 2, 3, 0, 0, 1, 1);
        #1 chk("t6_flush_ready", int'(in_ready), 0);
        tick();
        idle();
        chk("t6_count0", int'(rob_count), 0);
        chk("t6_head0", int'(rob_head), 0);
        chk("t6_counts0", int'({add_count, mul_count}), 0);
        chk("t6_no_valid", int'(out_valid), 0);
        apply(1, 15, 0, 0, 9, 0, 0, 0, 0);
        #1 chk("t6_illegal_ready", int'(in_ready), 1);
        tick();
        idle();
        chk("t6_err_illegal", int'(err_illegal), 1);
        chk("t6_illegal_no_valid", int'(out_valid), 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("t6_underflow", int'(err_underflow), 1);
        chk("t6_underflow_counts", int'({add_count, rob_count}), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
